// File: rtl/i2c_slave_mem.sv
// I2C target with a byte-addressed register file behind a persistent pointer.
// Pad inputs are synchronised and glitch-filtered; START/STOP override every state.
module i2c_slave_mem #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned MEM_AW   = 4,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Scl_in,
    input  logic              Sda_in,
    output logic              Sda_oe,
    output logic              Busy,
    output logic              Wr_vld,
    output logic [MEM_AW-1:0] Wr_addr,
    output logic [7:0]        Wr_data,
    output logic              Rd_vld,
    output logic [MEM_AW-1:0] Rd_addr,
    output logic [7:0]        Rd_data
);

    localparam int unsigned DEPTH = 1 << MEM_AW;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, REG, WDATA, ACK_DAT, RDATA, RACK, RNEXT, IGNORE
    } state_t;

    // Line index 0 is SCL, index 1 is SDA
    logic [1:0]       sync1, sync2, filt, filt_q;
    logic [CNT_W-1:0] fcnt [2];

    logic scl_rise, scl_fall, start, stop;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic [MEM_AW-1:0] ptr, ptr_nxt;
    logic              rw, rw_nxt;
    logic              sda_oe_nxt, busy_nxt;
    logic              wr_vld_nxt, rd_vld_nxt;
    logic [MEM_AW-1:0] wr_addr_nxt, rd_addr_nxt;
    logic [7:0]        wr_data_nxt, rd_data_nxt;
    logic              mem_we;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        mem_rd;
    logic [2:0]        bit_idx;

    // Synchroniser and run-length filter for both pad lines
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1  <= {Sda_in, Scl_in};
            sync2  <= sync1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CNT_W'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign scl_rise = filt[0] & ~filt_q[0];
    assign scl_fall = ~filt[0] & filt_q[0];
    assign start    = ~filt[1] & filt_q[1] & filt[0];
    assign stop     = filt[1] & ~filt_q[1] & filt[0];
    assign mem_rd   = mem[ptr];
    assign bit_idx  = ~bit_cnt[2:0];

    // Protocol next-state and registered-output logic
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        ptr_nxt     = ptr;
        rw_nxt      = rw;
        sda_oe_nxt  = Sda_oe;
        busy_nxt    = Busy;
        wr_vld_nxt  = 1'b0;
        wr_addr_nxt = Wr_addr;
        wr_data_nxt = Wr_data;
        rd_vld_nxt  = 1'b0;
        rd_addr_nxt = Rd_addr;
        rd_data_nxt = Rd_data;
        mem_we      = 1'b0;

        if (stop) begin
            state_nxt  = IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else if (start) begin
            state_nxt   = DEV;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                DEV, REG, WDATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[6:0], filt[1]};
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end else if (scl_fall && bit_cnt == CNT_W'(8)) begin
                        bit_cnt_nxt = '0;
                        if (state == DEV) begin
                            if (shreg[7:1] == DEV_ADDR) begin
                                sda_oe_nxt = 1'b1;
                                busy_nxt   = 1'b1;
                                rw_nxt     = shreg[0];
                                state_nxt  = ACK_DEV;
                            end else begin
                                state_nxt = IGNORE;
                            end
                        end else if (state == REG) begin
                            ptr_nxt    = shreg[MEM_AW-1:0];
                            sda_oe_nxt = 1'b1;
                            state_nxt  = ACK_DAT;
                        end else begin
                            mem_we      = 1'b1;
                            wr_vld_nxt  = 1'b1;
                            wr_addr_nxt = ptr;
                            wr_data_nxt = shreg;
                            ptr_nxt     = ptr + MEM_AW'(1);
                            sda_oe_nxt  = 1'b1;
                            state_nxt   = ACK_DAT;
                        end
                    end
                end
                ACK_DEV: begin
                    if (scl_fall) begin
                        bit_cnt_nxt = '0;
                        if (rw) begin
                            shreg_nxt  = mem_rd;
                            sda_oe_nxt = ~mem_rd[7];
                            state_nxt  = RDATA;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = REG;
                        end
                    end
                end
                ACK_DAT: begin
                    if (scl_fall) begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = '0;
                        state_nxt   = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end else if (scl_fall) begin
                        if (bit_cnt == CNT_W'(8)) begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = RACK;
                        end else begin
                            sda_oe_nxt = ~shreg[bit_idx];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        rd_vld_nxt  = 1'b1;
                        rd_addr_nxt = ptr;
                        rd_data_nxt = shreg;
                        if (!filt[1]) begin
                            ptr_nxt   = ptr + MEM_AW'(1);
                            state_nxt = RNEXT;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                end
                RNEXT: begin
                    // ptr has already advanced, so mem_rd is the next byte
                    if (scl_fall) begin
                        shreg_nxt   = mem_rd;
                        sda_oe_nxt  = ~mem_rd[7];
                        bit_cnt_nxt = '0;
                        state_nxt   = RDATA;
                    end
                end
                IGNORE: sda_oe_nxt = 1'b0;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, outputs and memory registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            ptr     <= '0;
            rw      <= 1'b0;
            Sda_oe  <= 1'b0;
            Busy    <= 1'b0;
            Wr_vld  <= 1'b0;
            Wr_addr <= '0;
            Wr_data <= '0;
            Rd_vld  <= 1'b0;
            Rd_addr <= '0;
            Rd_data <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            ptr     <= ptr_nxt;
            rw      <= rw_nxt;
            Sda_oe  <= sda_oe_nxt;
            Busy    <= busy_nxt;
            Wr_vld  <= wr_vld_nxt;
            Wr_addr <= wr_addr_nxt;
            Wr_data <= wr_data_nxt;
            Rd_vld  <= rd_vld_nxt;
            Rd_addr <= rd_addr_nxt;
            Rd_data <= rd_data_nxt;
            if (mem_we) mem[ptr] <= shreg;
        end
    end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: a table of bus steps with expected ACK/data/Busy,
// plus hand-written glitch and mid-read reset sequences.
module tb_i2c_slave_mem;

    localparam int unsigned MEM_AW = 4;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              scl_m, sda_m;
    logic              Scl_in, Sda_in;
    logic              Sda_oe, Busy, Wr_vld, Rd_vld;
    logic [MEM_AW-1:0] Wr_addr, Rd_addr;
    logic [7:0]        Wr_data, Rd_data;

    // Open-drain bus: the line is low if either side pulls it
    assign Scl_in = scl_m;
    assign Sda_in = sda_m & ~Sda_oe;

    i2c_slave_mem #(.DEV_ADDR(7'h50), .MEM_AW(MEM_AW), .FILT_LEN(3)) dut (
        .Clk(Clk), .Rst(Rst), .Scl_in(Scl_in), .Sda_in(Sda_in), .Sda_oe(Sda_oe),
        .Busy(Busy), .Wr_vld(Wr_vld), .Wr_addr(Wr_addr), .Wr_data(Wr_data),
        .Rd_vld(Rd_vld), .Rd_addr(Rd_addr), .Rd_data(Rd_data)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    logic [11:0] wr_got[$];
    logic [11:0] rd_got[$];

    always @(negedge Clk) begin
        if (!Rst && Wr_vld) wr_got.push_back({Wr_addr, Wr_data});
        if (!Rst && Rd_vld) rd_got.push_back({Rd_addr, Rd_data});
    end

    typedef enum logic [1:0] {S_START, S_STOP, S_WR, S_RD} kind_t;
    typedef struct {
        kind_t      kind;
        logic [7:0] val;       // byte to send, or master ACK bit in val[0] for reads
        logic       exp_ack;   // slave ACK on writes; Sda_oe in master-ACK slot on reads
        logic [7:0] exp_data;
        logic       exp_busy;
    } step_t;

    step_t steps[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic start_t();
        sda_m = 1'b1; cyc(10);
        scl_m = 1'b1; cyc(10);
        sda_m = 1'b0; cyc(10);
        scl_m = 1'b0; cyc(10);
    endtask

    task automatic stop_t();
        sda_m = 1'b0; cyc(10);
        scl_m = 1'b1; cyc(10);
        sda_m = 1'b1; cyc(10);
    endtask

    task automatic clock_bit(input logic b, output logic oe, output logic line);
        sda_m = b;    cyc(10);
        scl_m = 1'b1; cyc(10);
        oe    = Sda_oe;
        line  = Sda_in;
        cyc(10);
        scl_m = 1'b0; cyc(10);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack, output logic data_oe);
        logic oe, line;
        data_oe = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(b[i], oe, line);
            data_oe = data_oe | oe;
        end
        clock_bit(1'b1, oe, line);
        ack = oe;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d, output logic ack_oe);
        logic oe, line;
        logic [7:0] acc;
        acc = '0;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, oe, line);
            acc = {acc[6:0], line};
        end
        clock_bit(mack, oe, line);
        d      = acc;
        ack_oe = oe;
    endtask

    task automatic add(input kind_t k, input logic [7:0] v, input logic a,
                       input logic [7:0] d, input logic bsy);
        step_t s;
        s.kind = k; s.val = v; s.exp_ack = a; s.exp_data = d; s.exp_busy = bsy;
        steps.push_back(s);
    endtask

    logic        ack, doe, aoe;
    logic [7:0]  rdat;
    logic [11:0] wr_exp[$];
    logic [11:0] rd_exp[$];

    initial begin
        // Write 0x11,0x22 at pointer 3
        add(S_START, 8'h00, 1'b0, 8'h00, 1'b0);
        add(S_WR,    8'hA0, 1'b1, 8'h00, 1'b1);
        add(S_WR,    8'h03, 1'b1, 8'h00, 1'b1);
        add(S_WR,    8'h11, 1'b1, 8'h00, 1'b1);
        add(S_WR,    8'h22, 1'b1, 8'h00, 1'b1);
        add(S_STOP,  8'h00, 1'b0, 8'h00, 1'b0);
        // Random read from 3 via repeated START: ACK then NACK
        add(S_START, 8'h00, 1'b0, 8'h00, 1'b0);
        add(S_WR,    8'hA0, 1'b1, 8'h00, 1'b1);
        add(S_WR,    8'h03, 1'b1, 8'h00, 1'b1);
        add(S_START, 8'h00, 1'b0, 8'h00, 1'b0);
        add(S_WR,    8'hA1, 1'b1, 8'h00, 1'b1);
        add(S_RD,    8'h00, 1'b0, 8'h11, 1'b1);
        add(S_RD,    8'h01, 1'b0, 8'h22, 1'b1);
        add(S_STOP,  8'h00, 1'b0, 8'h00, 1'b0);
        // Wrong device address: no ACK anywhere, Busy low
        add(S_START, 8'h00, 1'b0, 8'h00, 1'b0);
        add(S_WR,    8'hA2, 1'b0, 8'h00, 1'b0);
        add(S_WR,    8'h05, 1'b0, 8'h00, 1'b0);
        add(S_WR,    8'h77, 1'b0, 8'h00, 1'b0);
        add(S_STOP,  8'h00, 1'b0, 8'h00, 1'b0);
        // mem[5] still zero
        add(S_START, 8'h00, 1'b0, 8'h00, 1'b0);
        add(S_WR,    8'hA0, 1'b1, 8'h00, 1'b1);
        add(S_WR,    8'h05, 1'b1, 8'h00, 1'b1);
        add(S_START, 8'h00, 1'b0, 8'h00, 1'b0);
        add(S_WR,    8'hA1, 1'b1, 8'h00, 1'b1);
        add(S_RD,    8'h01, 1'b0, 8'h00, 1'b1);
        add(S_STOP,  8'h00, 1'b0, 8'h00, 1'b0);
        // Pointer 0x1F truncates to 15; writes wrap to 0, then bare read at 1
        add(S_START, 8'h00, 1'b0, 8'h00, 1'b0);
        add(S_WR,    8'hA0, 1'b1, 8'h00, 1'b1);
        add(S_WR,    8'h1F, 1'b1, 8'h00, 1'b1);
        add(S_WR,    8'hAA, 1'b1, 8'h00, 1'b1);
        add(S_WR,    8'hBB, 1'b1, 8'h00, 1'b1);
        add(S_STOP,  8'h00, 1'b0, 8'h00, 1'b0);
        add(S_START, 8'h00, 1'b0, 8'h00, 1'b0);
        add(S_WR,    8'hA1, 1'b1, 8'h00, 1'b1);
        add(S_RD,    8'h01, 1'b0, 8'h00, 1'b1);
        add(S_STOP,  8'h00, 1'b0, 8'h00, 1'b0);

        wr_exp = '{12'h311, 12'h422, 12'hFAA, 12'h0BB};
        rd_exp = '{12'h311, 12'h422, 12'h500, 12'h100, 12'h000};

        Rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        cyc(3);
        chk("reset Sda_oe",  32'(Sda_oe),  0);
        chk("reset Busy",    32'(Busy),    0);
        chk("reset Wr_vld",  32'(Wr_vld),  0);
        chk("reset Wr_addr", 32'(Wr_addr), 0);
        chk("reset Wr_data", 32'(Wr_data), 0);
        chk("reset Rd_vld",  32'(Rd_vld),  0);
        chk("reset Rd_addr", 32'(Rd_addr), 0);
        chk("reset Rd_data", 32'(Rd_data), 0);
        Rst = 1'b0;
        cyc(10);

        foreach (steps[i]) begin
            case (steps[i].kind)
                S_START: start_t();
                S_STOP:  stop_t();
                S_WR: begin
                    wr_byte(steps[i].val, ack, doe);
                    chk($sformatf("step%0d slave_ack", i), 32'(ack), 32'(steps[i].exp_ack));
                    chk($sformatf("step%0d data_oe", i), 32'(doe), 0);
                end
                default: begin
                    rd_byte(steps[i].val[0], rdat, aoe);
                    chk($sformatf("step%0d rd_byte", i), 32'(rdat), 32'(steps[i].exp_data));
                    chk($sformatf("step%0d mack_oe", i), 32'(aoe), 32'(steps[i].exp_ack));
                end
            endcase
            chk($sformatf("step%0d busy", i), 32'(Busy), 32'(steps[i].exp_busy));
        end

        // 2-cycle SDA low with SCL high must not be a START
        cyc(10);
        sda_m = 1'b0; cyc(2);
        sda_m = 1'b1; scl_m = 1'b0; cyc(10);
        wr_byte(8'hA0, ack, doe);
        chk("glitch no_ack", 32'(ack), 0);
        chk("glitch busy", 32'(Busy), 0);
        scl_m = 1'b1; cyc(20);
        // SDA held low for 6 cycles with SCL high is a real START
        sda_m = 1'b0; cyc(6);
        scl_m = 1'b0; cyc(10);
        wr_byte(8'hA0, ack, doe);
        chk("long_start ack", 32'(ack), 1);
        chk("long_start busy", 32'(Busy), 1);
        stop_t();
        chk("long_start stop busy", 32'(Busy), 0);

        // Reset while driving bit 7 (=0) of mem[3]=0x11
        start_t();
        wr_byte(8'hA0, ack, doe);
        wr_byte(8'h03, ack, doe);
        start_t();
        wr_byte(8'hA1, ack, doe);
        chk("midread ack", 32'(ack), 1);
        chk("midread driving", 32'(Sda_oe), 1);
        Rst = 1'b1;
        @(posedge Clk); #1;
        chk("midread oe_drop", 32'(Sda_oe), 0);
        cyc(3);
        chk("midread Busy",    32'(Busy),    0);
        chk("midread Wr_addr", 32'(Wr_addr), 0);
        chk("midread Wr_data", 32'(Wr_data), 0);
        chk("midread Rd_addr", 32'(Rd_addr), 0);
        chk("midread Rd_data", 32'(Rd_data), 0);
        Rst = 1'b0;
        sda_m = 1'b1; scl_m = 1'b1; cyc(20);
        start_t();
        wr_byte(8'hA1, ack, doe);
        chk("postreset ack", 32'(ack), 1);
        rd_byte(1'b1, rdat, aoe);
        chk("postreset data", 32'(rdat), 0);
        stop_t();

        chk("wr count", 32'(wr_got.size()), 32'(wr_exp.size()));
        foreach (wr_exp[i])
            if (i < wr_got.size()) chk($sformatf("wr%0d addr_data", i), 32'(wr_got[i]), 32'(wr_exp[i]));
        chk("rd count", 32'(rd_got.size()), 32'(rd_exp.size()));
        foreach (rd_exp[i])
            if (i < rd_got.size()) chk($sformatf("rd%0d addr_data", i), 32'(rd_got[i]), 32'(rd_exp[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
